// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter that gives N requesters single-cycle access to one shared
// parallel_register control port and returns the post-operation value with an ack pulse.
module reg_access_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               async_nreset,
    input  logic [N-1:0]       i_req,
    input  logic [2*N-1:0]     i_op,
    input  logic [WIDTH*N-1:0] i_wdata,
    input  logic [WIDTH-1:0]   i_reg_q,
    output logic [1:0]         o_reg_ctrl,
    output logic [WIDTH-1:0]   o_reg_d,
    output logic [N-1:0]       o_gnt,
    output logic [N-1:0]       o_ack,
    output logic [WIDTH-1:0]   o_rdata,
    output logic               o_busy
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   w_win_nxt;
    logic [PW-1:0]   w_win;
    logic [PW:0]     w_idx;
    logic            w_found;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    r_ack;
    logic [N-1:0]    w_gnt_nxt;
    logic [N-1:0]    w_ack_nxt;
    logic            r_busy;
    logic            w_busy_nxt;
    logic [1:0]      r_reg_ctrl;
    logic [1:0]      w_reg_ctrl_nxt;
    logic [WIDTH-1:0] r_reg_d;
    logic [WIDTH-1:0] w_reg_d_nxt;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_rdata_nxt;

    // Round-robin search: first pending request at or above the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = {PW{1'b0}};
        w_idx   = {(PW+1){1'b0}};
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end else begin
                w_found = w_found;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: fixed IDLE -> ISSUE -> ACK -> IDLE service sequence.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, pointer and captured winner.
    always_comb begin
        w_gnt_nxt      = {N{1'b0}};
        w_ack_nxt      = {N{1'b0}};
        w_busy_nxt     = 1'b0;
        w_reg_ctrl_nxt = 2'd0;
        w_reg_d_nxt    = {WIDTH{1'b0}};
        w_rdata_nxt    = r_rdata;
        w_ptr_nxt      = r_ptr;
        w_win_nxt      = r_win;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt      = {{(N-1){1'b0}}, 1'b1} << w_win;
                    w_busy_nxt     = 1'b1;
                    w_reg_ctrl_nxt = i_op[{w_win, 1'b0} +: 2];
                    w_reg_d_nxt    = i_wdata[w_win*WIDTH +: WIDTH];
                    w_win_nxt      = w_win;
                end else begin
                    w_win_nxt      = r_win;
                end
            end
            ST_ISSUE: begin
                w_ack_nxt  = {{(N-1){1'b0}}, 1'b1} << r_win;
                w_busy_nxt = 1'b1;
                if (r_win == PW'(N-1)) begin
                    w_ptr_nxt = {PW{1'b0}};
                end else begin
                    w_ptr_nxt = r_win + PW'(1);
                end
            end
            ST_ACK: begin
                w_rdata_nxt = i_reg_q;
            end
            default: begin
                w_rdata_nxt = r_rdata;
            end
        endcase
    end

    // Output, pointer and winner registers.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_gnt      <= {N{1'b0}};
            r_ack      <= {N{1'b0}};
            r_busy     <= 1'b0;
            r_reg_ctrl <= 2'd0;
            r_reg_d    <= {WIDTH{1'b0}};
            r_rdata    <= {WIDTH{1'b0}};
            r_ptr      <= {PW{1'b0}};
            r_win      <= {PW{1'b0}};
        end else begin
            r_gnt      <= w_gnt_nxt;
            r_ack      <= w_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_reg_ctrl <= w_reg_ctrl_nxt;
            r_reg_d    <= w_reg_d_nxt;
            r_rdata    <= w_rdata_nxt;
            r_ptr      <= w_ptr_nxt;
            r_win      <= w_win_nxt;
        end
    end

    // The register only holds the post-op value from the start of ACK, so during ACK
    // rdata is taken straight from the register flop; afterwards the captured copy holds.
    assign o_rdata    = (r_state == ST_ACK) ? i_reg_q : r_rdata;
    assign o_gnt      = r_gnt;
    assign o_ack      = r_ack;
    assign o_busy     = r_busy;
    assign o_reg_ctrl = r_reg_ctrl;
    assign o_reg_d    = r_reg_d;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: directed cases plus randomized rounds,
// with a behavioural parallel_register attached to the control port.
module tb_reg_access_arbiter;
    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic               clk;
    logic               async_nreset;
    logic [N-1:0]       req;
    logic [2*N-1:0]     op;
    logic [WIDTH*N-1:0] wdata;
    logic [WIDTH-1:0]   reg_q;
    logic [1:0]         reg_ctrl;
    logic [WIDTH-1:0]   reg_d;
    logic [N-1:0]       gnt;
    logic [N-1:0]       ack;
    logic [WIDTH-1:0]   rdata;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int               w;
        logic [1:0]       o;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   mptr = 0;
    logic [WIDTH-1:0] mval = '0;

    reg_access_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .i_req        (req),
        .i_op         (op),
        .i_wdata      (wdata),
        .i_reg_q      (reg_q),
        .o_reg_ctrl   (reg_ctrl),
        .o_reg_d      (reg_d),
        .o_gnt        (gnt),
        .o_ack        (ack),
        .o_rdata      (rdata),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register: 0=hold, 1=load, 2=increment, 3=clear; cleared by the same reset.
    always @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) reg_q <= '0;
        else begin
            case (reg_ctrl)
                2'd1:    reg_q <= reg_d;
                2'd2:    reg_q <= reg_q + 8'd1;
                2'd3:    reg_q <= '0;
                default: reg_q <= reg_q;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] apply(input logic [1:0] o, input logic [WIDTH-1:0] d,
                                               input logic [WIDTH-1:0] v);
        int r;
        case (o)
            2'd1:    r = int'(d);
            2'd2:    r = (int'(v) + 1) % (1 << WIDTH);
            2'd3:    r = 0;
            default: r = int'(v);
        endcase
        return WIDTH'(r);
    endfunction

    function automatic logic [2*N-1:0] lane_op(input int i, input logic [1:0] o);
        logic [2*N-1:0] v = '0;
        v[2*i +: 2] = o;
        return v;
    endfunction

    function automatic logic [WIDTH*N-1:0] lane_d(input int i, input logic [WIDTH-1:0] d);
        logic [WIDTH*N-1:0] v = '0;
        v[WIDTH*i +: WIDTH] = d;
        return v;
    endfunction

    task automatic issue(input logic [N-1:0] m, input logic [2*N-1:0] o, input logic [WIDTH*N-1:0] d);
        exp_t e;
        req = m; op = o; wdata = d;
        e.w   = pick(m, mptr);
        e.o   = o[2*e.w +: 2];
        e.d   = d[WIDTH*e.w +: WIDTH];
        mval  = apply(e.o, e.d, mval);
        e.res = mval;
        mptr  = (e.w + 1) % N;
        exp_q.push_back(e);
    endtask

    task automatic round(input logic [N-1:0] m, input logic [2*N-1:0] o,
                         input logic [WIDTH*N-1:0] d, input bit late);
        issue(m, o, d);
        @(negedge clk);
        if (late) begin
            op    = (2*N)'($urandom);
            wdata = (WIDTH*N)'($urandom);
            req   = '0;
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
    endtask

    bit               prev_issue = 1'b0;
    logic [WIDTH-1:0] last_rd    = '0;

    // Monitor: checks every grant and ack against the front of the expected queue.
    always @(negedge clk) begin
        exp_t cur;
        if (mon_en) begin
            if (!async_nreset) begin
                check("ack_in_reset", ack, 0);
                prev_issue = 1'b0;
                last_rd    = '0;
            end else begin
                check("gnt_ack_overlap", gnt & ack, 0);
                check("onehot", ($countones(gnt | ack) <= 1), 1);
                if (prev_issue) begin
                    cur = exp_q.pop_front();
                    check("ack", ack, 32'(1) << cur.w);
                    check("rdata", rdata, cur.res);
                    check("busy_ack", busy, 1);
                    check("reg_ctrl_ack", reg_ctrl, 0);
                    check("reg_d_ack", reg_d, 0);
                    last_rd = cur.res;
                end else begin
                    check("no_ack", ack, 0);
                    check("rdata_hold", rdata, last_rd);
                end
                prev_issue = 1'b0;
                if (gnt != '0) begin
                    if (exp_q.size() == 0 || prev_issue) begin
                        check("unexpected_gnt", gnt, 0);
                    end else begin
                        check("gnt", gnt, 32'(1) << exp_q[0].w);
                        check("reg_ctrl", reg_ctrl, exp_q[0].o);
                        check("reg_d", reg_d, exp_q[0].d);
                        check("busy_issue", busy, 1);
                        prev_issue = 1'b1;
                    end
                end else if (ack == '0) begin
                    check("ctrl_outside_issue", reg_ctrl, 0);
                    check("busy_idle", busy, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        async_nreset = 1'b1;
        req = '0; op = '0; wdata = '0;
        repeat (2) @(negedge clk);
        #2 async_nreset = 1'b0;
        mon_en = 1'b1;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_reg_ctrl", reg_ctrl, 0);
        check("rst_reg_d", reg_d, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk);
        async_nreset = 1'b1;
        mptr = 0; mval = '0;
        repeat (10) begin
            @(negedge clk);
            check("idle_reg_ctrl", reg_ctrl, 0);
            check("idle_busy", busy, 0);
        end

        round(4'b0100, lane_op(2, 2'd1), lane_d(2, 8'hA5), 1'b0);
        round(4'b0001, lane_op(0, 2'd1), lane_d(0, 8'hFF), 1'b0);
        round(4'b0010, lane_op(1, 2'd2), lane_d(1, 8'h00), 1'b0);
        round(4'b1000, lane_op(3, 2'd1), lane_d(3, 8'h3C), 1'b0);
        round(4'b0100, lane_op(2, 2'd3), lane_d(2, 8'h99), 1'b0);
        round(4'b0001, lane_op(0, 2'd1), lane_d(0, 8'h5A), 1'b0);
        round(4'b0001, lane_op(0, 2'd0), lane_d(0, 8'h12), 1'b0);
        round(4'b0010, lane_op(1, 2'd1), lane_d(1, 8'h11), 1'b1);

        // Reset while the grant is being issued.
        issue(4'b0100, lane_op(2, 2'd1), lane_d(2, 8'h77));
        @(negedge clk);
        #2 async_nreset = 1'b0;
        #1;
        check("rst_issue_gnt", gnt, 0);
        check("rst_issue_reg_ctrl", reg_ctrl, 0);
        check("rst_issue_ack", ack, 0);
        check("rst_issue_busy", busy, 0);
        exp_q.delete();
        mptr = 0; mval = '0; req = '0;
        @(negedge clk);
        @(negedge clk);
        async_nreset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) round(4'b1111, '0, (WIDTH*N)'($urandom), 1'b0);
        round(4'b1001, '0, '0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            round(N'($urandom_range(1, (1 << N) - 1)), (2*N)'($urandom),
                  (WIDTH*N)'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Round-robin arbiter that shares one `parallel_register` instance between `N` requesters. It selects one pending request and drives the register's `ctrl`/`data_in` for exactly one cycle. It then returns the post-operation register value to the winner with a one-cycle acknowledge. It sits between the requester blocks and the register's control port. It is the only block allowed to drive that port.

## Interface

- `WIDTH`, 8: register data width; must equal the register's `WIDTH`.
- `N`, 4: number of requesters, 2..8.

- `clk`  in  1  clock, all state on rising edge.
- `async_nreset`  in  1  reset, asynchronous, active-low.
- `req`  in  N  per-requester request level; bit i = requester i.
- `op`  in  2*N  per-requester opcode; bits [2i+1:2i] for requester i. 0=NONE (read), 1=LOAD, 2=INCR, 3=CLR.
- `wdata`  in  WIDTH*N  per-requester load data; bits [WIDTH*i+WIDTH-1:WIDTH*i].
- `reg_q`  in  WIDTH  current register value (register `data_out`).
- `reg_ctrl`  out  2  to register `ctrl`.
- `reg_d`  out  WIDTH  to register `data_in`.
- `gnt`  out  N  one-hot grant, high during ISSUE.
- `ack`  out  N  one-hot completion pulse, high during ACK.
- `rdata`  out  WIDTH  register value after the granted op; valid while `ack` is nonzero.
- `busy`  out  1  high in ISSUE and ACK.

## Operation

- States: IDLE, ISSUE, ACK. Encoding is free. All outputs are registered.
- Reset, async, immediate:
  - state=IDLE, rr pointer=0.
  - `gnt`=0, `ack`=0, `busy`=0.
  - `reg_ctrl`=0 (NONE), `reg_d`=0, `rdata`=0.
- IDLE:
  - If `req`≠0, choose the winner w = the first set bit of `req`, scanning upward from the rr pointer with wrap (index N-1 wraps to 0).
  - Capture `op[w]` and `wdata[w]`.
  - Next state ISSUE, with `gnt`=1<<w, `reg_ctrl`=op[w], `reg_d`=wdata[w], `busy`=1.
  - Otherwise stay in IDLE with `reg_ctrl`=NONE.
- ISSUE, exactly one cycle: the register performs the op at the end of this cycle. Next state ACK:
  - `gnt`=0, `ack`=1<<w.
  - `reg_ctrl`=NONE, `reg_d`=0.
  - rr pointer = (w+1) mod N.
- ACK, exactly one cycle: `rdata` = `reg_q`, which is the post-op value. Next state IDLE: `ack`=0, `busy`=0.
- `rdata` holds its last value after ACK. It changes only on the next ACK.
- Only values seen at the IDLE→ISSUE edge matter. Changing `op`/`wdata` later does not affect the issued op.
- Dropping `req[w]` during ISSUE or ACK does not cancel anything: the op executes and `ack` still pulses.
- Requester protocol:
  - Hold `req` until `ack`.
  - Drop `req` in the cycle after `ack`, or it is taken as a new request.
  - A request still high in the IDLE cycle after ACK is re-arbitrated normally. Because the pointer has moved past it, the other requesters win first.
- INCR wraps modulo 2^WIDTH; the register handles this. The arbiter does no arithmetic except the pointer increment.
- Requests arriving during ISSUE/ACK wait. No request is lost while its `req` stays high.
- Fairness: with all N requesters continuously requesting, each is served once per N operations.
- Reset mid-operation: the FSM aborts to IDLE. No `ack` is issued. The register is cleared by the same reset.

## Timing

- Fixed 3-cycle service per op:
  - edge E0: IDLE sees `req`.
  - E1: ISSUE outputs valid.
  - E2: register updated; ACK outputs valid.
  - E3: back in IDLE.
- Latency from `req` sampled to `ack` high: 2 cycles. Peak throughput: 1 op per 3 cycles.
- `reg_ctrl` is non-NONE for exactly one cycle per grant and never outside ISSUE.
- At most one bit is set in `gnt` ∪ `ack` at any time. `gnt` and `ack` are never high together.

## Test plan

- Reset and idle: assert `async_nreset`=0 mid-cycle.
  - Required: all outputs 0 immediately.
  - Release with `req`=0 → `reg_ctrl` stays 0 and `busy` stays 0 for 10 cycles.
- Single LOAD, WIDTH=8: req[2]=1, op=1, wdata=0xA5.
  - Required: `gnt`=0b0100 and `reg_ctrl`=1, `reg_d`=0xA5 one cycle later.
  - Then `ack`=0b0100 with `rdata`=0xA5.
- INCR wrap: LOAD 0xFF, then INCR from requester 1.
  - Required: ACK of the INCR carries `rdata`=0x00.
  - CLR after a LOAD of 0x3C gives `rdata`=0x00. NONE gives the unchanged value.
- Round robin: `req`=0b1111 held and re-raised after each ack, starting with pointer 0.
  - Required: grant order 0,1,2,3,0.
  - With `req`=0b1001 after serving 0, next grant is 3.
- Late change / withdrawal: change `op`/`wdata` and drop `req` during ISSUE.
  - Required: the originally captured op executes and `ack` still pulses.
- Reset during ISSUE:
  - Required: `gnt` and `reg_ctrl` go to 0 immediately, no `ack` appears, and the pointer is 0 after release.
